// File: rtl/pos_to_cell_mapper_if.sv
// pos_to_cell_mapper_if
// Request/result bundle for pos_to_cell_mapper.
//   request : in_valid, in_ready, pos_x, pos_y
//   result  : out_valid, out_ready, cell_x, cell_y, off_x, off_y, in_grid
//             (+ edge_x, edge_y when CELL_EDGE_EN is defined)
// modport slave  : the mapper's view
// modport master : the producer/consumer view (position source + board logic)
interface pos_to_cell_mapper_if #(
    parameter int POS_W  = 10,
    parameter int CELL_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [POS_W-1:0]  pos_x;
    logic [POS_W-1:0]  pos_y;
    logic              out_valid;
    logic              out_ready;
    logic [CELL_W-1:0] cell_x;
    logic [CELL_W-1:0] cell_y;
    logic [POS_W-1:0]  off_x;
    logic [POS_W-1:0]  off_y;
    logic              in_grid;
`ifdef CELL_EDGE_EN
    logic              edge_x;
    logic              edge_y;
`endif

    modport slave (
        input  in_valid, pos_x, pos_y, out_ready,
        output in_ready, out_valid, cell_x, cell_y, off_x, off_y, in_grid
`ifdef CELL_EDGE_EN
        , edge_x, edge_y
`endif
    );

    modport master (
        output in_valid, pos_x, pos_y, out_ready,
        input  in_ready, out_valid, cell_x, cell_y, off_x, off_y, in_grid
`ifdef CELL_EDGE_EN
        , edge_x, edge_y
`endif
    );
endinterface

// File: rtl/pos_to_cell_mapper.sv
// pos_to_cell_mapper
// Maps a pixel position to a cell of a configurable grid using iterative
// subtraction, returning the cell index, the offset inside the cell and an
// in-grid flag.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : pos_to_cell_mapper_if.slave (valid/ready request and result)
// Optional feature: define CELL_EDGE_EN to add edge_x/edge_y result flags
// (set when the offset sits on the first or last pixel of the cell).
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | subtracting cell sizes on both axes in parallel
// DONE  | result held on the outputs until out_ready
module pos_to_cell_mapper #(
    parameter int POS_W     = 10,
    parameter int CELL_W    = 3,
    parameter int GRID_X    = 8,
    parameter int GRID_Y    = 8,
    parameter int CELL_PX_W = 80,
    parameter int CELL_PX_H = 60,
    parameter int ORIGIN_X  = 0,
    parameter int ORIGIN_Y  = 0
) (
    input logic               clk_in,
    input logic               rst_n_in,
    pos_to_cell_mapper_if.slave bus
);
    localparam logic [POS_W-1:0]  PX_W   = POS_W'(CELL_PX_W);
    localparam logic [POS_W-1:0]  PX_H   = POS_W'(CELL_PX_H);
    localparam logic [POS_W-1:0]  ORG_X  = POS_W'(ORIGIN_X);
    localparam logic [POS_W-1:0]  ORG_Y  = POS_W'(ORIGIN_Y);
    localparam logic [CELL_W-1:0] LAST_X = CELL_W'(GRID_X - 1);
    localparam logic [CELL_W-1:0] LAST_Y = CELL_W'(GRID_Y - 1);
`ifdef CELL_EDGE_EN
    localparam logic [POS_W-1:0]  END_W  = POS_W'(CELL_PX_W - 1);
    localparam logic [POS_W-1:0]  END_H  = POS_W'(CELL_PX_H - 1);
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    logic [POS_W-1:0]  rem_x_q, rem_y_q, rem_x_n, rem_y_n;
    logic [CELL_W-1:0] cnt_x_q, cnt_y_q, cnt_x_n, cnt_y_n;
    logic              done_x_q, done_y_q, done_x_n, done_y_n;
    logic              oob_x_q, oob_y_q, oob_x_n, oob_y_n;

    logic              accept;
    logic              calc_fin;
    logic              handshake;

    logic [CELL_W-1:0] cell_x_q, cell_y_q;
    logic [POS_W-1:0]  off_x_q, off_y_q;
    logic              in_grid_q;
`ifdef CELL_EDGE_EN
    logic              edge_x_q, edge_y_q;
`endif

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign handshake = (state_q == DONE) && bus.out_ready;
    assign calc_fin  = (state_q == CALC) && done_x_n && done_y_n;

    // One subtraction step per axis; an axis already finished holds its values.
    // A remainder still >= cell size at the last column means the position is
    // past the far edge, so the counter saturates instead of wrapping.
    always_comb begin
        rem_x_n  = rem_x_q;
        cnt_x_n  = cnt_x_q;
        done_x_n = done_x_q;
        oob_x_n  = oob_x_q;
        if (!done_x_q) begin
            if (rem_x_q < PX_W) begin
                done_x_n = 1'b1;
            end else if (cnt_x_q == LAST_X) begin
                done_x_n = 1'b1;
                oob_x_n  = 1'b1;
            end else begin
                rem_x_n = rem_x_q - PX_W;
                cnt_x_n = cnt_x_q + CELL_W'(1);
            end
        end
    end

    always_comb begin
        rem_y_n  = rem_y_q;
        cnt_y_n  = cnt_y_q;
        done_y_n = done_y_q;
        oob_y_n  = oob_y_q;
        if (!done_y_q) begin
            if (rem_y_q < PX_H) begin
                done_y_n = 1'b1;
            end else if (cnt_y_q == LAST_Y) begin
                done_y_n = 1'b1;
                oob_y_n  = 1'b1;
            end else begin
                rem_y_n = rem_y_q - PX_H;
                cnt_y_n = cnt_y_q + CELL_W'(1);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (calc_fin)  state_d = DONE;
            DONE:    if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath: origin underflow is caught by compare before the subtraction,
    // so the wrapped remainder of such an axis is never used.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rem_x_q  <= '0;
            rem_y_q  <= '0;
            cnt_x_q  <= '0;
            cnt_y_q  <= '0;
            done_x_q <= 1'b0;
            done_y_q <= 1'b0;
            oob_x_q  <= 1'b0;
            oob_y_q  <= 1'b0;
        end else if (accept) begin
            rem_x_q  <= bus.pos_x - ORG_X;
            rem_y_q  <= bus.pos_y - ORG_Y;
            cnt_x_q  <= '0;
            cnt_y_q  <= '0;
            done_x_q <= (bus.pos_x < ORG_X);
            done_y_q <= (bus.pos_y < ORG_Y);
            oob_x_q  <= (bus.pos_x < ORG_X);
            oob_y_q  <= (bus.pos_y < ORG_Y);
        end else if (state_q == CALC) begin
            rem_x_q  <= rem_x_n;
            rem_y_q  <= rem_y_n;
            cnt_x_q  <= cnt_x_n;
            cnt_y_q  <= cnt_y_n;
            done_x_q <= done_x_n;
            done_y_q <= done_y_n;
            oob_x_q  <= oob_x_n;
            oob_y_q  <= oob_y_n;
        end
    end

    // Result registers load only on CALC->DONE, so they hold through DONE and
    // keep their last value after the handshake.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cell_x_q  <= '0;
            cell_y_q  <= '0;
            off_x_q   <= '0;
            off_y_q   <= '0;
            in_grid_q <= 1'b0;
`ifdef CELL_EDGE_EN
            edge_x_q  <= 1'b0;
            edge_y_q  <= 1'b0;
`endif
        end else if (calc_fin) begin
            if (oob_x_n || oob_y_n) begin
                cell_x_q  <= '0;
                cell_y_q  <= '0;
                off_x_q   <= '0;
                off_y_q   <= '0;
                in_grid_q <= 1'b0;
`ifdef CELL_EDGE_EN
                edge_x_q  <= 1'b0;
                edge_y_q  <= 1'b0;
`endif
            end else begin
                cell_x_q  <= cnt_x_n;
                cell_y_q  <= cnt_y_n;
                off_x_q   <= rem_x_n;
                off_y_q   <= rem_y_n;
                in_grid_q <= 1'b1;
`ifdef CELL_EDGE_EN
                edge_x_q  <= (rem_x_n == '0) || (rem_x_n == END_W);
                edge_y_q  <= (rem_y_n == '0) || (rem_y_n == END_H);
`endif
            end
        end
    end

    assign bus.cell_x  = cell_x_q;
    assign bus.cell_y  = cell_y_q;
    assign bus.off_x   = off_x_q;
    assign bus.off_y   = off_y_q;
    assign bus.in_grid = in_grid_q;
`ifdef CELL_EDGE_EN
    assign bus.edge_x  = edge_x_q;
    assign bus.edge_y  = edge_y_q;
`endif
endmodule

// File: tb/tb_pos_to_cell_mapper.sv
// Testbench for pos_to_cell_mapper: two instances (default origin, and
// ORIGIN_X=16), a division-based reference model checked every cycle, and
// directed requests with hand-computed literal results.
module tb_pos_to_cell_mapper;
    localparam int PX_W = 80;
    localparam int PX_H = 60;
    localparam int GX   = 8;
    localparam int GY   = 8;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    int   errors   = 0;
    int   checks   = 0;

    always #5 clk_in = ~clk_in;

    pos_to_cell_mapper_if #(.POS_W(10), .CELL_W(3)) bus0 ();
    pos_to_cell_mapper_if #(.POS_W(10), .CELL_W(3)) bus1 ();

    pos_to_cell_mapper u_dut0 (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus0)
    );

    pos_to_cell_mapper #(.ORIGIN_X(16)) u_dut1 (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_axis(input int p, input int org, input int px, input int grid,
                                       output int c, output int off, output bit oob, output int q);
        int d;
        if (p < org) begin
            oob = 1; q = 0; c = 0; off = 0;
        end else begin
            d   = p - org;
            c   = d / px;
            off = d % px;
            if (c > grid - 1) begin
                oob = 1; q = grid - 1;
            end else begin
                oob = 0; q = c;
            end
        end
    endfunction

    int m_busy [2];
    int m_cnt  [2];
    int m_lat  [2];
    int m_cx   [2];
    int m_cy   [2];
    int m_ox   [2];
    int m_oy   [2];
    int m_ig   [2];
    int m_ex   [2];
    int m_ey   [2];

    function automatic void model_req(input int d, input int px, input int py);
        int cx, cy, ox, oy, qx, qy;
        bit bx, by;
        model_axis(px, (d == 1) ? 16 : 0, PX_W, GX, cx, ox, bx, qx);
        model_axis(py, 0, PX_H, GY, cy, oy, by, qy);
        m_ig[d]  = (!bx && !by) ? 1 : 0;
        m_cx[d]  = m_ig[d] ? cx : 0;
        m_cy[d]  = m_ig[d] ? cy : 0;
        m_ox[d]  = m_ig[d] ? ox : 0;
        m_oy[d]  = m_ig[d] ? oy : 0;
        m_ex[d]  = (m_ig[d] && (ox == 0 || ox == PX_W - 1)) ? 1 : 0;
        m_ey[d]  = (m_ig[d] && (oy == 0 || oy == PX_H - 1)) ? 1 : 0;
        m_lat[d] = ((qx > qy) ? qx : qy) + 2;
    endfunction

    // ---------------- bus access helpers ----------------
    function automatic int rd(input int d, input int which);
        int v;
        v = 0;
        if (d == 0) begin
            case (which)
                0: v = int'(bus0.in_valid);
                1: v = int'(bus0.in_ready);
                2: v = int'(bus0.out_valid);
                3: v = int'(bus0.out_ready);
                4: v = int'(bus0.cell_x);
                5: v = int'(bus0.cell_y);
                6: v = int'(bus0.off_x);
                7: v = int'(bus0.off_y);
                8: v = int'(bus0.in_grid);
                9: v = int'(bus0.pos_x);
                10: v = int'(bus0.pos_y);
`ifdef CELL_EDGE_EN
                11: v = int'(bus0.edge_x);
                12: v = int'(bus0.edge_y);
`endif
                default: v = 0;
            endcase
        end else begin
            case (which)
                0: v = int'(bus1.in_valid);
                1: v = int'(bus1.in_ready);
                2: v = int'(bus1.out_valid);
                3: v = int'(bus1.out_ready);
                4: v = int'(bus1.cell_x);
                5: v = int'(bus1.cell_y);
                6: v = int'(bus1.off_x);
                7: v = int'(bus1.off_y);
                8: v = int'(bus1.in_grid);
                9: v = int'(bus1.pos_x);
                10: v = int'(bus1.pos_y);
`ifdef CELL_EDGE_EN
                11: v = int'(bus1.edge_x);
                12: v = int'(bus1.edge_y);
`endif
                default: v = 0;
            endcase
        end
        return v;
    endfunction

    task automatic set_in(input int d, input bit v, input int px, input int py);
        if (d == 0) begin
            bus0.in_valid = v; bus0.pos_x = 10'(px); bus0.pos_y = 10'(py);
        end else begin
            bus1.in_valid = v; bus1.pos_x = 10'(px); bus1.pos_y = 10'(py);
        end
    endtask

    task automatic set_ordy(input int d, input bit v);
        if (d == 0) bus0.out_ready = v;
        else        bus1.out_ready = v;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n_in) begin
                chk("rst_out_valid", rd(d, 2), 0);
                chk("rst_cell_x", rd(d, 4), 0);
                chk("rst_cell_y", rd(d, 5), 0);
                chk("rst_off_x", rd(d, 6), 0);
                chk("rst_off_y", rd(d, 7), 0);
                chk("rst_in_grid", rd(d, 8), 0);
`ifdef CELL_EDGE_EN
                chk("rst_edge_x", rd(d, 11), 0);
                chk("rst_edge_y", rd(d, 12), 0);
`endif
                m_busy[d] = 0;
            end else if (m_busy[d] != 0) begin
                m_cnt[d]++;
                chk("busy_in_ready", rd(d, 1), 0);
                chk("out_valid_timing", rd(d, 2), (m_cnt[d] >= m_lat[d]) ? 1 : 0);
                if (rd(d, 2) == 1 && m_cnt[d] >= m_lat[d]) begin
                    chk("m_cell_x", rd(d, 4), m_cx[d]);
                    chk("m_cell_y", rd(d, 5), m_cy[d]);
                    chk("m_off_x", rd(d, 6), m_ox[d]);
                    chk("m_off_y", rd(d, 7), m_oy[d]);
                    chk("m_in_grid", rd(d, 8), m_ig[d]);
`ifdef CELL_EDGE_EN
                    chk("m_edge_x", rd(d, 11), m_ex[d]);
                    chk("m_edge_y", rd(d, 12), m_ey[d]);
`endif
                    if (rd(d, 3) == 1) m_busy[d] = 0;
                end
            end else begin
                chk("idle_out_valid", rd(d, 2), 0);
                chk("idle_in_ready", rd(d, 1), 1);
                if (rd(d, 0) == 1 && rd(d, 1) == 1) begin
                    m_busy[d] = 1;
                    m_cnt[d]  = 0;
                    model_req(d, rd(d, 9), rd(d, 10));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input int d, input int px, input int py, input int hold,
                          input int ecx, input int ecy, input int eox, input int eoy,
                          input int eig, input int elat, input int eex, input int eey);
        int n;
        @(posedge clk_in); #2;
        set_in(d, 1'b1, px, py);
        n = 0;
        @(negedge clk_in);
        while (rd(d, 1) == 0 && n < 50) begin
            @(negedge clk_in); n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 0, 1);
            set_in(d, 1'b0, 0, 0);
            return;
        end
        @(posedge clk_in); #2;
        set_in(d, 1'b0, 0, 0);
        n = 1;
        @(negedge clk_in);
        while (rd(d, 2) == 0 && n < 50) begin
            @(negedge clk_in); n++;
        end
        chk("lit_latency", n, elat);
        chk("lit_cell_x", rd(d, 4), ecx);
        chk("lit_cell_y", rd(d, 5), ecy);
        chk("lit_off_x", rd(d, 6), eox);
        chk("lit_off_y", rd(d, 7), eoy);
        chk("lit_in_grid", rd(d, 8), eig);
`ifdef CELL_EDGE_EN
        chk("lit_edge_x", rd(d, 11), eex);
        chk("lit_edge_y", rd(d, 12), eey);
`else
        if (eex < 0 || eey < 0) chk("lit_edge_args", 0, 1);
`endif
        repeat (hold) @(negedge clk_in);
        @(posedge clk_in); #2;
        set_ordy(d, 1'b1);
        @(posedge clk_in); #2;
        set_ordy(d, 1'b0);
        @(negedge clk_in);
        chk("post_hs_in_ready", rd(d, 1), 1);
        chk("post_hs_out_valid", rd(d, 2), 0);
        chk("post_hs_cell_x_kept", rd(d, 4), ecx);
        chk("post_hs_off_x_kept", rd(d, 6), eox);
    endtask

    initial begin
        set_in(0, 1'b0, 0, 0);
        set_in(1, 1'b0, 0, 0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        m_busy = '{0, 0};
        m_cnt  = '{0, 0};
        repeat (3) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

        //      d   px   py  hold cx cy  ox  oy ig lat ex ey
        do_req(0,   0,   0,  0,   0, 0,  0,  0, 1, 2,  1, 1);
        do_req(0, 639, 479,  0,   7, 7, 79, 59, 1, 9,  1, 1);
        do_req(0, 640, 100,  0,   0, 0,  0,  0, 0, 9,  0, 0);
        do_req(0, 300, 200,  5,   3, 3, 60, 20, 1, 5,  0, 0);
        do_req(0,  80,  59,  1,   1, 0,  0, 59, 1, 3,  1, 1);
        do_req(0,  81,  30,  0,   1, 0,  1, 30, 1, 3,  0, 0);
        do_req(0, 100, 700,  0,   0, 0,  0,  0, 0, 9,  0, 0);
        do_req(1,  10,   0,  0,   0, 0,  0,  0, 0, 2,  0, 0);
        do_req(1,  96,   0,  2,   1, 0,  0,  0, 1, 3,  1, 1);

        // Abort mid-calculation with reset.
        @(posedge clk_in); #2;
        set_in(0, 1'b1, 639, 479);
        @(posedge clk_in); #2;
        set_in(0, 1'b0, 0, 0);
        repeat (3) @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("abort_out_valid", rd(0, 2), 0);
        chk("abort_in_grid", rd(0, 8), 0);
        repeat (2) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        repeat (12) @(negedge clk_in);
        chk("abort_no_stale_valid", rd(0, 2), 0);
        chk("abort_in_ready", rd(0, 1), 1);

        do_req(0, 159, 119,  0,   1, 1, 79, 59, 1, 3,  1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
